sfp_sda_bridge: RTL and testbench

Open-drain SDA/SCL repeater between the Raspberry Pi I2C host bus, the on-chip I2C slave core, and one of the six SFP management buses. Filters every incoming line and arbitrates which side currently drives SDA low. It mirrors that low onto the other two sides, with a lock-out hold after each release so echoed lows never cause a latch-up. It changes the selected SFP channel only while the host bus is idle. It sits between the top-level SB_IO pin buffers and the I2C slave register core, and consumes the core's mux-select register.

---
 rtl/sfp_bridge_pkg.sv | 27 ++
 rtl/sfp_sda_bridge_if.sv | 23 ++
 rtl/i2c_line_filter.sv | 40 ++++
 rtl/sfp_sda_bridge.sv | 135 +++++++++++++
 tb/tb_sfp_sda_bridge.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sfp_bridge_pkg.sv
// Shared types and defaults for the SFP SDA/SCL bridge.
package sfp_bridge_pkg;

    localparam int NCH_DEF         = 6;
    localparam int HOLD_CYCLES_DEF = 10;
    localparam int FILT_LEN_DEF    = 3;
    localparam int DEFAULT_CH_DEF  = 3;

    // Bit positions in the low-request vector; lower index wins arbitration.
    localparam int PRIO_HOST  = 0;
    localparam int PRIO_SFP   = 1;
    localparam int PRIO_LOCAL = 2;

    typedef enum logic [2:0] {
        IDLE,
        HOST_DRV,
        SFP_DRV,
        LOC_DRV,
        HOLD
    } bridge_state_e;

    function automatic logic [2:0] map_sel(input logic [7:0] req, input int nch, input int dflt);
        if (int'(req) < nch) return req[2:0];
        return 3'(dflt);
    endfunction

endpackage

// File: rtl/sfp_sda_bridge_if.sv
// Pin-side bundle of the bridge: Pi host bus, slave core SDA and the SFP buses.
interface sfp_sda_bridge_if #(parameter int NCH = 6);

    logic           host_scl_in;
    logic           host_sda_in;
    logic           host_sda_out;
    logic           local_sda_in;
    logic           local_sda_out;
    logic [NCH-1:0] sfp_sda_in;
    logic [NCH-1:0] sfp_sda_out;
    logic [NCH-1:0] sfp_scl_out;

    modport master (
        output host_scl_in, host_sda_in, local_sda_in, sfp_sda_in,
        input  host_sda_out, local_sda_out, sfp_sda_out, sfp_scl_out
    );

    modport slave (
        input  host_scl_in, host_sda_in, local_sda_in, sfp_sda_in,
        output host_sda_out, local_sda_out, sfp_sda_out, sfp_scl_out
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a stability filter: the output follows the
// synced line only after FILT_LEN consecutive samples disagree with it.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            dout  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 != dout) begin
                if (cnt == CW'(FILT_LEN - 1)) begin
                    dout <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sfp_sda_bridge.sv
// Open-drain SDA repeater between Pi host, slave core and the selected SFP bus.
//   state    | meaning
//   IDLE     | nobody holds SDA low, all sides released
//   HOST_DRV | Pi holds SDA low, mirrored to SFP and core
//   SFP_DRV  | selected SFP holds SDA low, mirrored to Pi and core
//   LOC_DRV  | slave core holds SDA low, mirrored to Pi and SFP
//   HOLD     | lock-out after a release so echoed lows are ignored
module sfp_sda_bridge
    import sfp_bridge_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF,
    parameter int DEFAULT_CH  = DEFAULT_CH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            sel_req,
    sfp_sda_bridge_if.slave       pins,
    output logic [2:0]            sel_active,
    output logic                  bus_busy
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic           host_scl_f;
    logic           host_sda_f;
    logic           local_sda_f;
    logic [NCH-1:0] sfp_sda_f;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_host_scl (
        .clk(clk), .rst(rst), .din(pins.host_scl_in), .dout(host_scl_f));
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_host_sda (
        .clk(clk), .rst(rst), .din(pins.host_sda_in), .dout(host_sda_f));
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_local_sda (
        .clk(clk), .rst(rst), .din(pins.local_sda_in), .dout(local_sda_f));

    for (genvar i = 0; i < NCH; i++) begin : g_sfp_filt
        i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_sfp_sda (
            .clk(clk), .rst(rst), .din(pins.sfp_sda_in[i]), .dout(sfp_sda_f[i]));
    end

    bridge_state_e  state, state_nxt;
    logic [HW-1:0]  hold_cnt, hold_cnt_nxt;
    logic [2:0]     sel_nxt;
    logic           host_sda_d;
    logic           busy_nxt;
    logic [2:0]     low_req;
    logic           host_nxt, local_nxt, sfp_low;
    logic [NCH-1:0] sfp_sda_nxt, sfp_scl_nxt;

    always_comb begin
        sel_nxt      = sel_active;
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        busy_nxt     = bus_busy;
        host_nxt     = 1'b1;
        local_nxt    = 1'b1;
        sfp_low      = 1'b0;
        sfp_sda_nxt  = '1;
        sfp_scl_nxt  = '1;

        low_req             = '0;
        low_req[PRIO_HOST]  = ~host_sda_f;
        low_req[PRIO_SFP]   = ~sfp_sda_f[sel_active];
        low_req[PRIO_LOCAL] = ~local_sda_f;

        // Channel switch is only safe while the host bus is idle and nothing is mirrored.
        if (state == IDLE && !bus_busy) sel_nxt = map_sel(sel_req, NCH, DEFAULT_CH);

        if (host_scl_f && host_sda_d && !host_sda_f)      busy_nxt = 1'b1;
        else if (host_scl_f && !host_sda_d && host_sda_f) busy_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (low_req[PRIO_HOST])       state_nxt = HOST_DRV;
                else if (low_req[PRIO_SFP])   state_nxt = SFP_DRV;
                else if (low_req[PRIO_LOCAL]) state_nxt = LOC_DRV;
            end
            HOST_DRV: if (!low_req[PRIO_HOST]) begin
                state_nxt    = HOLD;
                hold_cnt_nxt = HW'(HOLD_CYCLES);
            end
            SFP_DRV: if (!low_req[PRIO_SFP]) begin
                state_nxt    = HOLD;
                hold_cnt_nxt = HW'(HOLD_CYCLES);
            end
            LOC_DRV: if (!low_req[PRIO_LOCAL]) begin
                state_nxt    = HOLD;
                hold_cnt_nxt = HW'(HOLD_CYCLES);
            end
            HOLD: begin
                if (hold_cnt == '0) state_nxt = IDLE;
                else                hold_cnt_nxt = hold_cnt - HW'(1);
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they land in the same edge as it.
        case (state_nxt)
            HOST_DRV: begin sfp_low  = 1'b1; local_nxt = 1'b0; end
            SFP_DRV:  begin host_nxt = 1'b0; local_nxt = 1'b0; end
            LOC_DRV:  begin host_nxt = 1'b0; sfp_low   = 1'b1; end
            default:  ;
        endcase

        if (sfp_low) sfp_sda_nxt[sel_nxt] = 1'b0;
        sfp_scl_nxt[sel_nxt] = host_scl_f;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            hold_cnt           <= '0;
            sel_active         <= 3'(DEFAULT_CH);
            bus_busy           <= 1'b0;
            host_sda_d         <= 1'b1;
            pins.host_sda_out  <= 1'b1;
            pins.local_sda_out <= 1'b1;
            pins.sfp_sda_out   <= '1;
            pins.sfp_scl_out   <= '1;
        end else begin
            state              <= state_nxt;
            hold_cnt           <= hold_cnt_nxt;
            sel_active         <= sel_nxt;
            bus_busy           <= busy_nxt;
            host_sda_d         <= host_sda_f;
            pins.host_sda_out  <= host_nxt;
            pins.local_sda_out <= local_nxt;
            pins.sfp_sda_out   <= sfp_sda_nxt;
            pins.sfp_scl_out   <= sfp_scl_nxt;
        end
    end

endmodule

// File: tb/tb_sfp_sda_bridge.sv
// Scoreboard bench: the stimulus driver runs a pin-history reference model and
// queues expected outputs; a negedge monitor pops and compares them.
module tb_sfp_sda_bridge;

    localparam int NCH  = 6;
    localparam int HOLD = 10;
    localparam int FL   = 3;
    localparam int DCH  = 3;

    localparam int M_IDLE = 0, M_HOST = 1, M_SFP = 2, M_LOC = 3, M_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sel_req;
    logic [2:0] sel_active;
    logic       bus_busy;

    always #5 clk = ~clk;

    sfp_sda_bridge_if #(.NCH(NCH)) pins ();

    sfp_sda_bridge #(
        .NCH(NCH), .HOLD_CYCLES(HOLD), .FILT_LEN(FL), .DEFAULT_CH(DCH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sel_req(sel_req),
        .pins(pins.slave),
        .sel_active(sel_active),
        .bus_busy(bus_busy)
    );

    typedef struct packed {
        logic           host;
        logic           loc;
        logic [NCH-1:0] sfp;
        logic [NCH-1:0] scl;
        logic [2:0]     sel;
        logic           busy;
    } out_t;

    typedef struct {
        int   tag;
        out_t v;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) edge_cnt++;

    // stimulus state
    bit           h_scl, h_sda, l_sda, r;
    bit [NCH-1:0] s_sda;
    int           sreq;

    // reference model state: raw pin history, filtered view, owner and hold timer
    bit [8:0] hist[$];
    bit [8:0] filt;
    bit       host_prev, busy;
    int       owner, hold_left, sel;
    out_t     mo;

    function automatic out_t outputs(input bit scl);
        out_t o;
        o.host = !(owner == M_SFP || owner == M_LOC);
        o.loc  = !(owner == M_HOST || owner == M_SFP);
        o.sfp  = '1;
        if (owner == M_HOST || owner == M_LOC) o.sfp[sel] = 1'b0;
        o.scl      = '1;
        o.scl[sel] = scl;
        o.sel      = 3'(sel);
        o.busy     = busy;
        return o;
    endfunction

    task automatic model_edge();
        bit [8:0] agree;
        bit scl, hs, ls, ss, start, stop;
        int nsel, n;
        if (r) begin
            hist.delete();
            repeat (FL + 3) hist.push_back(9'h1FF);
            filt = '1; host_prev = 1'b1; busy = 1'b0;
            owner = M_IDLE; hold_left = 0; sel = DCH;
            mo = outputs(1'b1);
            return;
        end
        hist.push_back({s_sda, l_sda, h_sda, h_scl});
        scl = filt[0]; hs = filt[1]; ls = filt[2]; ss = filt[3 + sel];
        start = host_prev && !hs && scl;
        stop  = !host_prev && hs && scl;
        nsel  = (owner == M_IDLE && !busy) ? ((sreq < NCH) ? sreq : DCH) : sel;
        case (owner)
            M_IDLE: begin
                if (!hs)      owner = M_HOST;
                else if (!ss) owner = M_SFP;
                else if (!ls) owner = M_LOC;
            end
            M_HOST: if (hs) begin owner = M_HOLD; hold_left = HOLD; end
            M_SFP:  if (ss) begin owner = M_HOLD; hold_left = HOLD; end
            M_LOC:  if (ls) begin owner = M_HOLD; hold_left = HOLD; end
            default: begin
                if (hold_left == 0) owner = M_IDLE;
                else                hold_left--;
            end
        endcase
        if (start)     busy = 1'b1;
        else if (stop) busy = 1'b0;
        host_prev = hs;
        sel = nsel;
        mo = outputs(scl);
        // a line's filtered value adopts the pin level seen FL times in a row, two syncs ago
        n = hist.size();
        agree = '1;
        for (int i = 1; i < FL; i++) agree &= ~(hist[n-3] ^ hist[n-3-i]);
        filt = (agree & hist[n-3]) | (~agree & filt);
        if (n > 32) void'(hist.pop_front());
    endtask

    task automatic drive();
        pins.host_scl_in  = h_scl;
        pins.host_sda_in  = h_sda;
        pins.local_sda_in = l_sda;
        pins.sfp_sda_in   = s_sda;
        rst               = r;
        sel_req           = 8'(sreq);
    endtask

    task automatic step(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
            model_edge();
            e.tag = edge_cnt + 1;
            e.v   = mo;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        out_t act;
        while (q.size() > 0 && q[0].tag <= edge_cnt) begin
            e   = q.pop_front();
            act = {pins.host_sda_out, pins.local_sda_out, pins.sfp_sda_out,
                   pins.sfp_scl_out, sel_active, bus_busy};
            vectors++;
            if (act !== e.v) begin
                miscompares++;
                $display("FAIL outputs edge %0d: got host=%b loc=%b sfp=%b scl=%b sel=%0d busy=%b, want host=%b loc=%b sfp=%b scl=%b sel=%0d busy=%b",
                         e.tag, act.host, act.loc, act.sfp, act.scl, act.sel, act.busy,
                         e.v.host, e.v.loc, e.v.sfp, e.v.scl, e.v.sel, e.v.busy);
            end
        end
    end

    initial begin
        h_scl = 1; h_sda = 1; l_sda = 1; s_sda = '1; r = 1; sreq = DCH;
        drive();
        step(3);
        r = 0;
        step(100);

        // host START and hold, then release with an echoed SFP low
        h_sda = 0; step(20);
        h_sda = 1; s_sda[3] = 0; step(8);
        s_sda[3] = 1; step(30);

        // host and SFP low together: host wins
        h_sda = 0; s_sda[3] = 0; step(20);
        h_sda = 1; s_sda[3] = 1; step(30);

        // channel request mid-transaction waits for STOP and IDLE
        h_sda = 0; step(10);
        h_scl = 0; step(10);
        sreq = 1;  step(10);
        h_scl = 1; step(10);
        h_sda = 1; step(40);
        sreq = 7;  step(20);
        sreq = DCH; step(10);

        // short glitch on the SFP line
        s_sda[3] = 0; step(2);
        s_sda[3] = 1; step(20);

        // reset while the SFP side owns the bus
        s_sda[3] = 0; step(15);
        r = 1; step(1);
        r = 0; step(10);
        s_sda[3] = 1; step(30);

        // local core drives
        l_sda = 0; step(15);
        l_sda = 1; step(30);

        for (int k = 0; k < 600; k++) begin
            int pick;
            pick = $urandom_range(0, 9);
            case (pick)
                0: h_scl = ~h_scl;
                1: h_sda = ~h_sda;
                2: l_sda = ~l_sda;
                9: sreq  = $urandom_range(0, 7);
                default: s_sda[pick-3] = ~s_sda[pick-3];
            endcase
            r = ($urandom_range(0, 99) == 0);
            step($urandom_range(1, 12));
            r = 0;
        end

        h_scl = 1; h_sda = 1; l_sda = 1; s_sda = '1;
        step(40);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left uncompared, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
